cdb_rs_entry: RTL and testbench

Single reservation-station entry that generalises CDB result listening to NUM_SRC operand slots snooping NUM_CDB parallel common data buses. It adds an explicit free/occupied state, an allocate handshake, an issue handshake towards the functional unit, flush, and asynchronous reset. It sits between the dispatch stage, which allocates into it, and one functional unit, which drains it. A CDB producer is expected to drive each destination tag on at most one bus per cycle.

---
 rtl/cdb_rs_entry.sv | 139 +++++++++++++
 tb/tb_cdb_rs_entry.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cdb_rs_entry.sv
// Single reservation-station entry: holds one instruction, snoops NUM_CDB result buses
// for missing source operands, and hands the complete instruction to its functional unit.
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_FREE    | entry empty, alloc_ready=1, CDB traffic ignored
// ST_WAITING | entry occupied, at least one source slot still waits for a tag
// ST_READY   | entry occupied, all operands present, issue_valid=1
module cdb_rs_entry #(
   parameter int DATA_WIDTH    = 4,
   parameter int CDB_TAG_WIDTH = 4,
   parameter int NUM_SRC       = 2,
   parameter int NUM_CDB       = 2,
   parameter int OP_WIDTH      = 3
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic [NUM_CDB-1:0]                cdb_in_valid,
   input  logic [NUM_CDB*CDB_TAG_WIDTH-1:0]  cdb_in_tag,
   input  logic [NUM_CDB*DATA_WIDTH-1:0]     cdb_in_data,
   input  logic                              alloc_valid,
   output logic                              alloc_ready,
   input  logic [OP_WIDTH-1:0]               alloc_op,
   input  logic [CDB_TAG_WIDTH-1:0]          alloc_dest_tag,
   input  logic [NUM_SRC*DATA_WIDTH-1:0]     alloc_src_data,
   input  logic [NUM_SRC-1:0]                alloc_src_is_valid,
   input  logic                              flush,
   output logic                              issue_valid,
   input  logic                              issue_ready,
   output logic [OP_WIDTH-1:0]               issue_op,
   output logic [CDB_TAG_WIDTH-1:0]          issue_dest_tag,
   output logic [NUM_SRC*DATA_WIDTH-1:0]     issue_src_data,
   output logic [NUM_SRC-1:0]                src_valid,
   output logic                              busy
);

   typedef enum logic [1:0] {
      ST_FREE    = 2'd0,
      ST_WAITING = 2'd1,
      ST_READY   = 2'd2
   } state_t;

   state_t                                state_q, state_d;
   logic [NUM_SRC-1:0]                    src_valid_q, src_valid_d;
   logic [NUM_SRC-1:0][DATA_WIDTH-1:0]    src_data_q, src_data_d;
   logic [OP_WIDTH-1:0]                   op_q, op_d;
   logic [CDB_TAG_WIDTH-1:0]              dest_q, dest_d;
   logic [NUM_SRC-1:0]                    hit;
   logic [NUM_SRC-1:0][DATA_WIDTH-1:0]    hit_data;
   logic [NUM_SRC-1:0][CDB_TAG_WIDTH-1:0] look_tag;
   logic                                  alloc_fire;
   logic                                  issue_fire;

   assign alloc_fire = alloc_valid && (state_q == ST_FREE);
   assign issue_fire = issue_ready && (state_q == ST_READY);

   // In FREE the compare runs on the incoming tag (same-cycle bypass), otherwise on the stored one.
   // Buses are scanned high to low so the lowest-index hit overrides.
   always_comb begin
      for (int s = 0; s < NUM_SRC; s++) begin
         look_tag[s] = (state_q == ST_FREE) ? alloc_src_data[s*DATA_WIDTH +: CDB_TAG_WIDTH]
                                            : src_data_q[s][CDB_TAG_WIDTH-1:0];
         hit[s]      = 1'b0;
         hit_data[s] = '0;
         for (int i = NUM_CDB - 1; i >= 0; i--) begin
            if (cdb_in_valid[i] &&
                (cdb_in_tag[i*CDB_TAG_WIDTH +: CDB_TAG_WIDTH] == look_tag[s])) begin
               hit[s]      = 1'b1;
               hit_data[s] = cdb_in_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      src_valid_d = src_valid_q;
      src_data_d  = src_data_q;
      op_d        = op_q;
      dest_d      = dest_q;
      if (flush) begin
         state_d     = ST_FREE;
         src_valid_d = '0;
      end else if (issue_fire) begin
         state_d     = ST_FREE;
         src_valid_d = '0;
      end else if (alloc_fire) begin
         op_d   = alloc_op;
         dest_d = alloc_dest_tag;
         for (int s = 0; s < NUM_SRC; s++) begin
            if (alloc_src_is_valid[s]) begin
               src_data_d[s]  = alloc_src_data[s*DATA_WIDTH +: DATA_WIDTH];
               src_valid_d[s] = 1'b1;
            end else if (hit[s]) begin
               src_data_d[s]  = hit_data[s];
               src_valid_d[s] = 1'b1;
            end else begin
               src_data_d[s]                      = '0;
               src_data_d[s][CDB_TAG_WIDTH-1:0]   = alloc_src_data[s*DATA_WIDTH +: CDB_TAG_WIDTH];
               src_valid_d[s]                     = 1'b0;
            end
         end
         state_d = (&src_valid_d) ? ST_READY : ST_WAITING;
      end else if (state_q == ST_WAITING) begin
         for (int s = 0; s < NUM_SRC; s++) begin
            if (!src_valid_q[s] && hit[s]) begin
               src_data_d[s]  = hit_data[s];
               src_valid_d[s] = 1'b1;
            end
         end
         state_d = (&src_valid_d) ? ST_READY : ST_WAITING;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_FREE;
         src_valid_q <= '0;
         src_data_q  <= '0;
         op_q        <= '0;
         dest_q      <= '0;
      end else begin
         state_q     <= state_d;
         src_valid_q <= src_valid_d;
         src_data_q  <= src_data_d;
         op_q        <= op_d;
         dest_q      <= dest_d;
      end
   end

   assign busy           = (state_q != ST_FREE);
   assign alloc_ready    = (state_q == ST_FREE);
   assign issue_valid    = (state_q == ST_READY);
   assign src_valid      = src_valid_q;
   assign issue_op       = op_q;
   assign issue_dest_tag = dest_q;
   assign issue_src_data = src_data_q;

endmodule

// File: tb/tb_cdb_rs_entry.sv
// Bench for cdb_rs_entry: directed vector table, reset corner cases, then randomized
// traffic against a slot-level behavioural model.
module tb_cdb_rs_entry;
   localparam int DW = 4;
   localparam int TW = 4;
   localparam int NS = 2;
   localparam int NC = 2;
   localparam int OW = 3;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [NC-1:0]     cdb_in_valid;
   logic [NC*TW-1:0]  cdb_in_tag;
   logic [NC*DW-1:0]  cdb_in_data;
   logic              alloc_valid;
   logic              alloc_ready;
   logic [OW-1:0]     alloc_op;
   logic [TW-1:0]     alloc_dest_tag;
   logic [NS*DW-1:0]  alloc_src_data;
   logic [NS-1:0]     alloc_src_is_valid;
   logic              flush;
   logic              issue_valid;
   logic              issue_ready;
   logic [OW-1:0]     issue_op;
   logic [TW-1:0]     issue_dest_tag;
   logic [NS*DW-1:0]  issue_src_data;
   logic [NS-1:0]     src_valid;
   logic              busy;

   cdb_rs_entry #(.DATA_WIDTH(DW), .CDB_TAG_WIDTH(TW), .NUM_SRC(NS), .NUM_CDB(NC), .OP_WIDTH(OW)) dut (
      .clk(clk), .rst_n(rst_n),
      .cdb_in_valid(cdb_in_valid), .cdb_in_tag(cdb_in_tag), .cdb_in_data(cdb_in_data),
      .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_op(alloc_op),
      .alloc_dest_tag(alloc_dest_tag), .alloc_src_data(alloc_src_data),
      .alloc_src_is_valid(alloc_src_is_valid), .flush(flush),
      .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_op(issue_op),
      .issue_dest_tag(issue_dest_tag), .issue_src_data(issue_src_data),
      .src_valid(src_valid), .busy(busy)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic check_reset(input string tag);
      check({tag, " busy"},        32'(busy), 32'd0);
      check({tag, " issue_valid"}, 32'(issue_valid), 32'd0);
      check({tag, " alloc_ready"}, 32'(alloc_ready), 32'd1);
      check({tag, " src_valid"},   32'(src_valid), 32'd0);
      check({tag, " issue_op"},    32'(issue_op), 32'd0);
      check({tag, " dest_tag"},    32'(issue_dest_tag), 32'd0);
      check({tag, " src_data"},    32'(issue_src_data), 32'd0);
   endtask

   task automatic drive_idle();
      alloc_valid = 1'b0; alloc_op = '0; alloc_dest_tag = '0; alloc_src_data = '0;
      alloc_src_is_valid = '0; cdb_in_valid = '0; cdb_in_tag = '0; cdb_in_data = '0;
      flush = 1'b0; issue_ready = 1'b0;
   endtask

   typedef struct {
      logic          av;
      logic [OW-1:0] op;
      logic [TW-1:0] dest;
      logic [NS*DW-1:0] src;
      logic [NS-1:0] isv;
      logic [NC-1:0] cv;
      logic [NC*TW-1:0] ct;
      logic [NC*DW-1:0] cd;
      logic          fl;
      logic          ir;
      logic          e_busy;
      logic          e_iv;
      logic [NS-1:0] e_sv;
      logic [NS*DW-1:0] e_sd;
      logic [OW-1:0] e_op;
      logic [TW-1:0] e_dest;
   } vec_t;

   vec_t tbl[16];

   // Behavioural reference: one record per operand slot plus an occupied flag.
   bit            m_busy;
   bit            m_val  [NS];
   logic [DW-1:0] m_data [NS];
   logic [OW-1:0] m_op;
   logic [TW-1:0] m_dest;

   function automatic bit bus_lookup(input logic [TW-1:0] tag, output logic [DW-1:0] d);
      bit found = 1'b0;
      d = '0;
      for (int i = 0; i < NC; i++)
         if (!found && cdb_in_valid[i] && cdb_in_tag[i*TW +: TW] == tag) begin
            found = 1'b1;
            d     = cdb_in_data[i*DW +: DW];
         end
      return found;
   endfunction

   task automatic model_reset();
      m_busy = 1'b0; m_op = '0; m_dest = '0;
      for (int s = 0; s < NS; s++) begin m_val[s] = 1'b0; m_data[s] = '0; end
   endtask

   task automatic model_step();
      bit            all_v = 1'b1;
      logic [DW-1:0] d;
      for (int s = 0; s < NS; s++) all_v = all_v && m_val[s];
      if (flush) begin
         m_busy = 1'b0;
         for (int s = 0; s < NS; s++) m_val[s] = 1'b0;
      end else if (m_busy && all_v && issue_ready) begin
         m_busy = 1'b0;
         for (int s = 0; s < NS; s++) m_val[s] = 1'b0;
      end else if (!m_busy && alloc_valid) begin
         m_busy = 1'b1; m_op = alloc_op; m_dest = alloc_dest_tag;
         for (int s = 0; s < NS; s++) begin
            if (alloc_src_is_valid[s]) begin
               m_data[s] = alloc_src_data[s*DW +: DW]; m_val[s] = 1'b1;
            end else if (bus_lookup(alloc_src_data[s*DW +: TW], d)) begin
               m_data[s] = d; m_val[s] = 1'b1;
            end else begin
               m_data[s] = DW'(alloc_src_data[s*DW +: TW]); m_val[s] = 1'b0;
            end
         end
      end else if (m_busy) begin
         for (int s = 0; s < NS; s++)
            if (!m_val[s] && bus_lookup(m_data[s][TW-1:0], d)) begin
               m_data[s] = d; m_val[s] = 1'b1;
            end
      end
   endtask

   task automatic compare_model(input int cyc);
      bit               all_v = 1'b1;
      logic [NS-1:0]    e_sv;
      logic [NS*DW-1:0] e_sd;
      for (int s = 0; s < NS; s++) begin
         all_v = all_v && m_val[s];
         e_sv[s] = m_val[s];
         e_sd[s*DW +: DW] = m_data[s];
      end
      check($sformatf("rnd%0d busy", cyc),        32'(busy), 32'(m_busy));
      check($sformatf("rnd%0d alloc_ready", cyc), 32'(alloc_ready), 32'(!m_busy));
      check($sformatf("rnd%0d issue_valid", cyc), 32'(issue_valid), 32'(m_busy && all_v));
      check($sformatf("rnd%0d src_valid", cyc),   32'(src_valid), 32'(e_sv));
      check($sformatf("rnd%0d src_data", cyc),    32'(issue_src_data), 32'(e_sd));
      check($sformatf("rnd%0d op", cyc),          32'(issue_op), 32'(m_op));
      check($sformatf("rnd%0d dest", cyc),        32'(issue_dest_tag), 32'(m_dest));
   endtask

   initial begin
      //        av op    dest   src    isv    cv     ct     cd     fl ir | busy iv sv     sd     op    dest
      tbl[0]  = '{1, 3'h5, 4'hA, 8'h93, 2'b11, 2'b00, 8'h00, 8'h00, 0, 0, 1, 1, 2'b11, 8'h93, 3'h5, 4'hA};
      tbl[1]  = '{0, 3'h0, 4'h0, 8'h00, 2'b00, 2'b00, 8'h00, 8'h00, 0, 0, 1, 1, 2'b11, 8'h93, 3'h5, 4'hA};
      tbl[2]  = '{0, 3'h0, 4'h0, 8'h00, 2'b00, 2'b00, 8'h00, 8'h00, 0, 0, 1, 1, 2'b11, 8'h93, 3'h5, 4'hA};
      tbl[3]  = '{0, 3'h0, 4'h0, 8'h00, 2'b00, 2'b00, 8'h00, 8'h00, 0, 1, 0, 0, 2'b00, 8'h93, 3'h5, 4'hA};
      tbl[4]  = '{1, 3'h1, 4'h3, 8'h72, 2'b00, 2'b00, 8'h00, 8'h00, 0, 0, 1, 0, 2'b00, 8'h72, 3'h1, 4'h3};
      tbl[5]  = '{0, 3'h0, 4'h0, 8'h00, 2'b00, 2'b01, 8'h07, 8'h0C, 0, 0, 1, 0, 2'b10, 8'hC2, 3'h1, 4'h3};
      tbl[6]  = '{0, 3'h0, 4'h0, 8'h00, 2'b00, 2'b10, 8'h20, 8'h10, 0, 0, 1, 1, 2'b11, 8'hC1, 3'h1, 4'h3};
      tbl[7]  = '{0, 3'h0, 4'h0, 8'h00, 2'b00, 2'b00, 8'h00, 8'h00, 0, 1, 0, 0, 2'b00, 8'hC1, 3'h1, 4'h3};
      tbl[8]  = '{1, 3'h2, 4'h4, 8'h85, 2'b10, 2'b11, 8'h55, 8'h6E, 0, 0, 1, 1, 2'b11, 8'h8E, 3'h2, 4'h4};
      tbl[9]  = '{0, 3'h0, 4'h0, 8'h00, 2'b00, 2'b00, 8'h00, 8'h00, 0, 1, 0, 0, 2'b00, 8'h8E, 3'h2, 4'h4};
      tbl[10] = '{1, 3'h6, 4'h5, 8'h44, 2'b00, 2'b00, 8'h00, 8'h00, 0, 0, 1, 0, 2'b00, 8'h44, 3'h6, 4'h5};
      tbl[11] = '{1, 3'h7, 4'hF, 8'h11, 2'b11, 2'b10, 8'h30, 8'h90, 0, 0, 1, 0, 2'b00, 8'h44, 3'h6, 4'h5};
      tbl[12] = '{0, 3'h0, 4'h0, 8'h00, 2'b00, 2'b10, 8'h40, 8'hB0, 0, 0, 1, 1, 2'b11, 8'hBB, 3'h6, 4'h5};
      tbl[13] = '{0, 3'h0, 4'h0, 8'h00, 2'b00, 2'b00, 8'h00, 8'h00, 1, 1, 0, 0, 2'b00, 8'hBB, 3'h6, 4'h5};
      tbl[14] = '{0, 3'h0, 4'h0, 8'h00, 2'b00, 2'b01, 8'h04, 8'h02, 0, 0, 0, 0, 2'b00, 8'hBB, 3'h6, 4'h5};
      tbl[15] = '{1, 3'h1, 4'h1, 8'h12, 2'b11, 2'b00, 8'h00, 8'h00, 1, 0, 0, 0, 2'b00, 8'hBB, 3'h6, 4'h5};

      drive_idle();
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      #1 check_reset("reset_async");
      @(posedge clk);
      #3 rst_n = 1'b1;
      repeat (3) begin
         @(posedge clk); #1;
         check_reset("idle");
      end

      for (int k = 0; k < 16; k++) begin
         alloc_valid = tbl[k].av; alloc_op = tbl[k].op; alloc_dest_tag = tbl[k].dest;
         alloc_src_data = tbl[k].src; alloc_src_is_valid = tbl[k].isv;
         cdb_in_valid = tbl[k].cv; cdb_in_tag = tbl[k].ct; cdb_in_data = tbl[k].cd;
         flush = tbl[k].fl; issue_ready = tbl[k].ir;
         @(posedge clk); #1;
         check($sformatf("vec%0d busy", k),        32'(busy), 32'(tbl[k].e_busy));
         check($sformatf("vec%0d alloc_ready", k), 32'(alloc_ready), 32'(!tbl[k].e_busy));
         check($sformatf("vec%0d issue_valid", k), 32'(issue_valid), 32'(tbl[k].e_iv));
         check($sformatf("vec%0d src_valid", k),   32'(src_valid), 32'(tbl[k].e_sv));
         check($sformatf("vec%0d src_data", k),    32'(issue_src_data), 32'(tbl[k].e_sd));
         check($sformatf("vec%0d op", k),          32'(issue_op), 32'(tbl[k].e_op));
         check($sformatf("vec%0d dest", k),        32'(issue_dest_tag), 32'(tbl[k].e_dest));
      end

      // Reset in the middle of a held READY entry clears everything without a clock edge.
      drive_idle();
      alloc_valid = 1'b1; alloc_op = 3'h3; alloc_dest_tag = 4'h9;
      alloc_src_data = 8'h5A; alloc_src_is_valid = 2'b11;
      @(posedge clk); #1;
      check("midrst pre busy", 32'(busy), 32'd1);
      check("midrst pre issue_valid", 32'(issue_valid), 32'd1);
      drive_idle();
      #3 rst_n = 1'b0;
      #1 check_reset("midrst_async");
      #2 rst_n = 1'b1;
      @(posedge clk); #1;
      check_reset("midrst_release");

      model_reset();
      for (int c = 0; c < 2000; c++) begin
         alloc_valid        = 1'($urandom_range(0, 1));
         alloc_op           = 3'($urandom_range(0, 7));
         alloc_dest_tag     = 4'($urandom_range(0, 15));
         alloc_src_is_valid = 2'($urandom_range(0, 3));
         for (int s = 0; s < NS; s++)
            alloc_src_data[s*DW +: DW] = alloc_src_is_valid[s] ? 4'($urandom_range(0, 15))
                                                               : 4'($urandom_range(0, 3));
         for (int i = 0; i < NC; i++) begin
            cdb_in_valid[i]        = ($urandom_range(0, 2) == 0);
            cdb_in_tag[i*TW +: TW] = 4'($urandom_range(0, 3));
            cdb_in_data[i*DW +: DW] = 4'($urandom_range(0, 15));
         end
         flush       = ($urandom_range(0, 15) == 0);
         issue_ready = ($urandom_range(0, 2) != 0);
         model_step();
         @(posedge clk); #1;
         compare_model(c);
      end

      drive_idle();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
